// File: rtl/tsn_sp_tx_arbiter.sv
// Strict-priority egress frame scheduler for one TX port: eligibility request, grant hold, IFG.
// Optional XMIT watchdog enabled by defining TSN_SP_ARB_WATCHDOG_EN.
module tsn_sp_tx_arbiter #(
    parameter int unsigned PORT_FIFO_PRI_NUM = 8,
    parameter int unsigned IFG_CYCLES        = 3,
    parameter int unsigned WDOG_CYCLES       = 4096
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [PORT_FIFO_PRI_NUM-1:0] i_fifoc_empty,
    output logic                         o_elig_req,
    input  logic [PORT_FIFO_PRI_NUM-1:0] i_queue,
    input  logic                         i_queue_vld,
    output logic [PORT_FIFO_PRI_NUM-1:0] o_grant,
    output logic                         o_grant_vld,
    input  logic                         i_mac_tx_axis_valid,
    input  logic                         i_mac_tx_axis_ready,
    input  logic                         i_mac_tx_axis_last,
    output logic                         o_send_flag,
    output logic [PORT_FIFO_PRI_NUM-1:0] o_scheduing_rst,
    output logic                         o_scheduing_rst_vld,
    output logic [15:0]                  o_frame_beats,
    output logic                         o_wdog_err
);

    localparam int unsigned N        = PORT_FIFO_PRI_NUM;
    localparam int unsigned BEAT_W   = 16;
    localparam int unsigned IFG_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [IFG_W-1:0]  IFG_LOAD = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

    if (WDOG_CYCLES < 2 || WDOG_CYCLES > 65536) begin : g_bad_wdog_cfg
        $error("WDOG_CYCLES must lie in 2..65536");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_ELIG,
        S_XMIT,
        S_IFG
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [N-1:0]        grant_d;
    logic                grant_vld_d;
    logic                elig_req_d;
    logic                send_flag_d;
    logic [N-1:0]        sched_rst_d;
    logic                sched_rst_vld_d;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   beat_cnt_d;
    logic [BEAT_W-1:0]   frame_beats_d;
    logic [IFG_W-1:0]    ifg_cnt;
    logic [IFG_W-1:0]    ifg_cnt_d;
    logic                release_c;

    logic [N-1:0]        cand_c;
    logic [N-1:0]        pick_c;
    logic                beat_c;
    logic [BEAT_W-1:0]   beat_inc_c;

`ifdef TSN_SP_ARB_WATCHDOG_EN
    localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES - 1);
    logic [15:0] wdog_cnt;
    logic [15:0] wdog_cnt_d;
    logic        wdog_err_d;
`endif

    assign cand_c     = i_queue & ~i_fifoc_empty;
    assign beat_c     = i_mac_tx_axis_valid & i_mac_tx_axis_ready;
    assign beat_inc_c = (beat_cnt == BEAT_MAX) ? beat_cnt : beat_cnt + 16'd1;

    // Highest set candidate bit wins (bit N-1 is the top priority).
    always_comb begin
        pick_c = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_c[i]) begin
                pick_c = N'(1) << i;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d         = state;
        grant_d         = o_grant;
        grant_vld_d     = o_grant_vld;
        send_flag_d     = 1'b0;
        sched_rst_d     = '0;
        sched_rst_vld_d = 1'b0;
        beat_cnt_d      = beat_cnt;
        frame_beats_d   = o_frame_beats;
        ifg_cnt_d       = ifg_cnt;
        release_c       = 1'b0;
`ifdef TSN_SP_ARB_WATCHDOG_EN
        wdog_cnt_d      = wdog_cnt;
        wdog_err_d      = o_wdog_err;
`endif

        unique case (state)
            S_IDLE: begin
                if (i_fifoc_empty != '1) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT_ELIG;
            end
            S_WAIT_ELIG: begin
                if (i_queue_vld) begin
                    sched_rst_vld_d = 1'b1;
                    if (cand_c == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        grant_d     = pick_c;
                        grant_vld_d = 1'b1;
                        send_flag_d = 1'b1;
                        sched_rst_d = pick_c;
                        beat_cnt_d  = '0;
`ifdef TSN_SP_ARB_WATCHDOG_EN
                        wdog_cnt_d  = '0;
`endif
                        state_d     = S_XMIT;
                    end
                end
            end
            S_XMIT: begin
                if (beat_c) begin
                    beat_cnt_d = beat_inc_c;
                    if (i_mac_tx_axis_last) begin
                        frame_beats_d = beat_inc_c;
                        release_c     = 1'b1;
                    end
                end
`ifdef TSN_SP_ARB_WATCHDOG_EN
                // A stalled frame is abandoned without publishing its beat count.
                if (beat_c) begin
                    wdog_cnt_d = '0;
                end else if (wdog_cnt == WDOG_LIMIT) begin
                    release_c  = 1'b1;
                    wdog_err_d = 1'b1;
                end else begin
                    wdog_cnt_d = wdog_cnt + 16'd1;
                end
`endif
                if (release_c) begin
                    grant_d     = '0;
                    grant_vld_d = 1'b0;
                    ifg_cnt_d   = IFG_LOAD;
                    state_d     = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;
                end
            end
            S_IFG: begin
                if (ifg_cnt == '0) begin
                    state_d = S_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt - IFG_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        elig_req_d = (state_d == S_REQ);
    end

    // Registered outputs and datapath counters.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_grant             <= '0;
            o_grant_vld         <= 1'b0;
            o_elig_req          <= 1'b0;
            o_send_flag         <= 1'b0;
            o_scheduing_rst     <= '0;
            o_scheduing_rst_vld <= 1'b0;
            o_frame_beats       <= '0;
            beat_cnt            <= '0;
            ifg_cnt             <= '0;
        end else begin
            o_grant             <= grant_d;
            o_grant_vld         <= grant_vld_d;
            o_elig_req          <= elig_req_d;
            o_send_flag         <= send_flag_d;
            o_scheduing_rst     <= sched_rst_d;
            o_scheduing_rst_vld <= sched_rst_vld_d;
            o_frame_beats       <= frame_beats_d;
            beat_cnt            <= beat_cnt_d;
            ifg_cnt             <= ifg_cnt_d;
        end
    end

`ifdef TSN_SP_ARB_WATCHDOG_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wdog_cnt   <= '0;
            o_wdog_err <= 1'b0;
        end else begin
            wdog_cnt   <= wdog_cnt_d;
            o_wdog_err <= wdog_err_d;
        end
    end
`else
    assign o_wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_tsn_sp_tx_arbiter.sv
// Directed bench for tsn_sp_tx_arbiter: arbitration vector table plus multi-cycle corner sequences.
module tb_tsn_sp_tx_arbiter;

    localparam int unsigned N    = 8;
    localparam int unsigned IFG  = 3;
    localparam int unsigned WDOG = 16;

    typedef struct packed {
        logic [N-1:0] empty;
        logic [N-1:0] queue;
        logic [N-1:0] exp;
    } vec_t;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic [N-1:0] i_fifoc_empty;
    logic         o_elig_req;
    logic [N-1:0] i_queue;
    logic         i_queue_vld;
    logic [N-1:0] o_grant;
    logic         o_grant_vld;
    logic         i_mac_tx_axis_valid;
    logic         i_mac_tx_axis_ready;
    logic         i_mac_tx_axis_last;
    logic         o_send_flag;
    logic [N-1:0] o_scheduing_rst;
    logic         o_scheduing_rst_vld;
    logic [15:0]  o_frame_beats;
    logic         o_wdog_err;

    int checks = 0;
    int errors = 0;
    vec_t vecs [9];

    tsn_sp_tx_arbiter #(
        .PORT_FIFO_PRI_NUM(N),
        .IFG_CYCLES(IFG),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_fifoc_empty(i_fifoc_empty),
        .o_elig_req(o_elig_req),
        .i_queue(i_queue),
        .i_queue_vld(i_queue_vld),
        .o_grant(o_grant),
        .o_grant_vld(o_grant_vld),
        .i_mac_tx_axis_valid(i_mac_tx_axis_valid),
        .i_mac_tx_axis_ready(i_mac_tx_axis_ready),
        .i_mac_tx_axis_last(i_mac_tx_axis_last),
        .o_send_flag(o_send_flag),
        .o_scheduing_rst(o_scheduing_rst),
        .o_scheduing_rst_vld(o_scheduing_rst_vld),
        .o_frame_beats(o_frame_beats),
        .o_wdog_err(o_wdog_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1ns after the edge. Grant invariant checked every cycle.
    task automatic tick();
        logic [N-1:0] gm;
        @(posedge i_clk);
        #1;
        gm = o_grant - 8'd1;
        checks++;
        if (((o_grant & gm) != '0) || (o_grant_vld !== (|o_grant))) begin
            errors++;
            $display("FAIL grant_invariant: grant=%0h grant_vld=%0b", o_grant, o_grant_vld);
        end
    endtask

    task automatic request(input logic [N-1:0] empty, input string name);
        int n;
        i_fifoc_empty = empty;
        n = 0;
        while (o_elig_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_elig_req"}, 32'(o_elig_req), 32'd1);
    endtask

    // Called while o_elig_req is visible; answers one cycle later with the given eligibility.
    task automatic respond(input logic [N-1:0] queue, input logic [N-1:0] exp, input string name);
        tick();
        i_queue     = queue;
        i_queue_vld = 1'b1;
        tick();
        i_queue_vld = 1'b0;
        i_queue     = '0;
        chk({name, "_grant"},     32'(o_grant),             32'(exp));
        chk({name, "_grant_vld"}, 32'(o_grant_vld),         32'(|exp));
        chk({name, "_send_flag"}, 32'(o_send_flag),         32'(|exp));
        chk({name, "_sched_rst"}, 32'(o_scheduing_rst),     32'(exp));
        chk({name, "_sched_vld"}, 32'(o_scheduing_rst_vld), 32'd1);
    endtask

    task automatic send_frame(input int beats, input int stall_beat, input int stall_len);
        for (int b = 1; b <= beats; b++) begin
            if (b == stall_beat) begin
                i_mac_tx_axis_valid = 1'b1;
                i_mac_tx_axis_ready = 1'b0;
                i_mac_tx_axis_last  = (b == beats);
                repeat (stall_len) tick();
            end
            i_mac_tx_axis_valid = 1'b1;
            i_mac_tx_axis_ready = 1'b1;
            i_mac_tx_axis_last  = (b == beats);
            tick();
        end
        i_mac_tx_axis_valid = 1'b0;
        i_mac_tx_axis_ready = 1'b0;
        i_mac_tx_axis_last  = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_grant"},       32'(o_grant),             32'd0);
        chk({name, "_grant_vld"},   32'(o_grant_vld),         32'd0);
        chk({name, "_elig_req"},    32'(o_elig_req),          32'd0);
        chk({name, "_send_flag"},   32'(o_send_flag),         32'd0);
        chk({name, "_sched_rst"},   32'(o_scheduing_rst),     32'd0);
        chk({name, "_sched_vld"},   32'(o_scheduing_rst_vld), 32'd0);
        chk({name, "_frame_beats"}, 32'(o_frame_beats),       32'd0);
        chk({name, "_wdog_err"},    32'(o_wdog_err),          32'd0);
    endtask

    initial begin
        int gap;
        int n;

        vecs[0] = '{empty: 8'hF5, queue: 8'h0A, exp: 8'h08};
        vecs[1] = '{empty: 8'hFB, queue: 8'h84, exp: 8'h04};
        vecs[2] = '{empty: 8'h00, queue: 8'hFF, exp: 8'h80};
        vecs[3] = '{empty: 8'hFE, queue: 8'h01, exp: 8'h01};
        vecs[4] = '{empty: 8'h00, queue: 8'h3C, exp: 8'h20};
        vecs[5] = '{empty: 8'h0F, queue: 8'h0F, exp: 8'h00};
        vecs[6] = '{empty: 8'h55, queue: 8'h2A, exp: 8'h20};
        vecs[7] = '{empty: 8'hE0, queue: 8'h1F, exp: 8'h10};
        vecs[8] = '{empty: 8'hFE, queue: 8'h00, exp: 8'h00};

        i_rst_n             = 1'b0;
        i_fifoc_empty       = '1;
        i_queue             = '0;
        i_queue_vld         = 1'b0;
        i_mac_tx_axis_valid = 1'b0;
        i_mac_tx_axis_ready = 1'b0;
        i_mac_tx_axis_last  = 1'b0;

        repeat (3) tick();
        chk_all_zero("reset");
        i_rst_n = 1'b1;
        tick();
        tick();
        chk("idle_all_empty_no_req", 32'(o_elig_req), 32'd0);

        for (int i = 0; i < 9; i++) begin
            request(vecs[i].empty, $sformatf("vec%0d", i));
            respond(vecs[i].queue, vecs[i].exp, $sformatf("vec%0d", i));
            if (vecs[i].exp != '0) begin
                send_frame(i % 3 + 1, 0, 0);
                chk($sformatf("vec%0d_grant_drop", i), 32'(o_grant), 32'd0);
                chk($sformatf("vec%0d_frame_beats", i), 32'(o_frame_beats), 32'(i % 3 + 1));
            end
        end

        // Nothing eligible: single zero result strobe, re-request no sooner than 2 cycles.
        request(8'hFE, "t2");
        tick();
        i_queue     = 8'h00;
        i_queue_vld = 1'b1;
        tick();
        i_queue_vld = 1'b0;
        chk("t2_sched_vld", 32'(o_scheduing_rst_vld), 32'd1);
        chk("t2_sched_rst", 32'(o_scheduing_rst), 32'd0);
        chk("t2_no_grant", 32'(o_grant_vld), 32'd0);
        gap = 1;
        tick();
        gap++;
        chk("t2_sched_vld_one_cycle", 32'(o_scheduing_rst_vld), 32'd0);
        while (o_elig_req !== 1'b1 && gap < 20) begin
            tick();
            gap++;
        end
        chk("t2_rereq_seen", 32'(o_elig_req), 32'd1);
        chk("t2_rereq_gap_ge2", 32'(gap >= 2), 32'd1);

        // q7 frame of 5 beats with a 2-cycle ready stall on beat 3, then IFG spacing.
        i_fifoc_empty = 8'h7F;
        respond(8'hFF, 8'h80, "t3");
        tick();
        chk("t3_send_flag_pulse", 32'(o_send_flag), 32'd0);
        chk("t3_sched_vld_pulse", 32'(o_scheduing_rst_vld), 32'd0);
        chk("t3_grant_held", 32'(o_grant), 32'h80);
        send_frame(5, 3, 2);
        chk("t3_grant_drop", 32'(o_grant), 32'd0);
        chk("t3_grant_vld_drop", 32'(o_grant_vld), 32'd0);
        chk("t3_frame_beats", 32'(o_frame_beats), 32'd5);
        n = 0;
        while (o_elig_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t3_ifg_spacing", 32'(n), 32'(IFG + 1));

        // Strobes outside WAIT_ELIG are ignored.
        respond(8'h00, 8'h00, "t3_drain");
        i_fifoc_empty = '1;
        i_queue       = 8'hFF;
        i_queue_vld   = 1'b1;
        repeat (3) tick();
        i_queue_vld   = 1'b0;
        i_queue       = '0;
        chk("stray_vld_no_grant", 32'(o_grant_vld), 32'd0);
        chk("stray_vld_no_sched", 32'(o_scheduing_rst_vld), 32'd0);
        chk("stray_vld_no_req", 32'(o_elig_req), 32'd0);

        // Higher-priority arrivals during XMIT do not pre-empt.
        request(8'hFD, "np");
        respond(8'hFF, 8'h02, "np");
        i_fifoc_empty = 8'h00;
        i_queue       = 8'hFF;
        i_queue_vld   = 1'b1;
        repeat (4) tick();
        i_queue_vld   = 1'b0;
        i_queue       = '0;
        chk("np_grant_held", 32'(o_grant), 32'h02);
        chk("np_no_sched", 32'(o_scheduing_rst_vld), 32'd0);
        send_frame(2, 0, 0);
        chk("np_frame_beats", 32'(o_frame_beats), 32'd2);

        // Reset on beat 2 of a 6-beat frame.
        request(8'hBF, "t5");
        respond(8'hFF, 8'h40, "t5");
        i_mac_tx_axis_valid = 1'b1;
        i_mac_tx_axis_ready = 1'b1;
        i_mac_tx_axis_last  = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b0;
        tick();
        i_mac_tx_axis_valid = 1'b0;
        i_mac_tx_axis_ready = 1'b0;
        chk_all_zero("t5_midframe_reset");
        i_rst_n = 1'b1;
        request(8'hBF, "t5_rearb");
        respond(8'hFF, 8'h40, "t5_rearb");
        send_frame(6, 0, 0);
        chk("t5_frame_beats", 32'(o_frame_beats), 32'd6);

        // Beats stop after the grant.
        request(8'hF7, "t6");
        respond(8'hFF, 8'h08, "t6");
        repeat (15) tick();
        chk("t6_hold_15", 32'(o_grant), 32'h08);
        tick();
`ifdef TSN_SP_ARB_WATCHDOG_EN
        chk("t6_wdog_release", 32'(o_grant), 32'd0);
        chk("t6_wdog_release_vld", 32'(o_grant_vld), 32'd0);
        chk("t6_wdog_err", 32'(o_wdog_err), 32'd1);
        repeat (8) tick();
        chk("t6_wdog_err_sticky", 32'(o_wdog_err), 32'd1);
        chk("t6_frame_beats_kept", 32'(o_frame_beats), 32'd6);
`else
        chk("t6_no_wdog_hold", 32'(o_grant), 32'h08);
        chk("t6_no_wdog_err", 32'(o_wdog_err), 32'd0);
        repeat (10) tick();
        chk("t6_no_wdog_hold_long", 32'(o_grant), 32'h08);
        send_frame(1, 0, 0);
        chk("t6_late_frame_beats", 32'(o_frame_beats), 32'd1);
        chk("t6_late_grant_drop", 32'(o_grant), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
